// File: rtl/pwm_pkg.sv
// Shared PWM constants and capture FSM states; the 4-bit generator uses the same frame constants.
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW,
    STUCK
  } pwm_state_e;

  localparam int unsigned PWM_PERIOD = 16;
  localparam int unsigned DUTY_W     = 4;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the PWM pin plus a previous-value register for edge detection.
module pwm_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s_meta;
  logic s_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_meta <= 1'b0;
      level  <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= pwm_in;
      level  <= s_meta;
      s_prev <= level;
    end
  end

  assign rise = level & ~s_prev;
  assign fall = ~level & s_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, recovers the generator
// duty code for 16-cycle frames and flags an edge-less (stuck) input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty_code,
  output logic              code_ok,
  output logic              meas_valid,
  output logic              stuck,
  output logic              stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic s, rise, fall;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .pwm_in (pwm_in),
    .level  (s),
    .rise   (rise),
    .fall   (fall)
  );

  pwm_state_e       state, state_nxt;
  logic [CNT_W-1:0] per_ctr, per_nxt;
  logic [CNT_W-1:0] idle_ctr, idle_nxt;
  logic [CNT_W-1:0] hi_lat;
  logic             do_latch, do_publish, do_stuck, do_unstuck;
  logic             per_sat;

  assign per_sat = (per_ctr == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= WAIT_RISE;
    else         state <= state_nxt;
  end

  // Edge handling takes priority over saturation, so a rise on the last count still publishes.
  always_comb begin
    state_nxt  = state;
    per_nxt    = per_ctr;
    idle_nxt   = '0;
    do_latch   = 1'b0;
    do_publish = 1'b0;
    do_stuck   = 1'b0;
    do_unstuck = 1'b0;
    case (state)
      WAIT_RISE: begin
        if (rise) begin
          state_nxt = HIGH;
          per_nxt   = ONE;
        end else if (idle_ctr == CNT_MAX) begin
          state_nxt = STUCK;
          do_stuck  = 1'b1;
        end else begin
          idle_nxt  = idle_ctr + ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          do_latch  = 1'b1;
          state_nxt = LOW;
          per_nxt   = per_sat ? per_ctr : per_ctr + ONE;
        end else if (per_sat) begin
          state_nxt = STUCK;
          do_stuck  = 1'b1;
        end else begin
          per_nxt   = per_ctr + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          do_publish = 1'b1;
          state_nxt  = HIGH;
          per_nxt    = ONE;
        end else if (per_sat) begin
          state_nxt  = STUCK;
          do_stuck   = 1'b1;
        end else begin
          per_nxt    = per_ctr + ONE;
        end
      end
      STUCK: begin
        if (rise) begin
          do_unstuck = 1'b1;
          state_nxt  = HIGH;
          per_nxt    = ONE;
        end else if (fall) begin
          do_unstuck = 1'b1;
          state_nxt  = WAIT_RISE;
        end
      end
      default: state_nxt = WAIT_RISE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      per_ctr     <= '0;
      idle_ctr    <= '0;
      hi_lat      <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_code   <= '0;
      code_ok     <= 1'b0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      per_ctr    <= per_nxt;
      idle_ctr   <= idle_nxt;
      meas_valid <= do_publish;
      if (do_latch) hi_lat <= per_ctr;
      if (do_publish) begin
        high_cnt   <= hi_lat;
        period_cnt <= per_ctr;
        code_ok    <= (per_ctr == CNT_W'(PWM_PERIOD));
        if (per_ctr == CNT_W'(PWM_PERIOD)) duty_code <= DUTY_W'(hi_lat - ONE);
      end
      // A generator at full duty never falls; report it as code 15 rather than leaving a stale code.
      if (do_stuck) begin
        stuck       <= 1'b1;
        stuck_level <= s;
        if (s) begin
          duty_code <= '1;
          code_ok   <= 1'b1;
        end
      end
      if (do_unstuck) stuck <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a pin-level reference model queues expected measurements,
// a monitor pops and compares them on every meas_valid.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int STUCK_LIM = 255;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              pwm_in = 1'b0;
  logic [CNT_W-1:0]  high_cnt, period_cnt;
  logic [DUTY_W-1:0] duty_code;
  logic              code_ok, meas_valid, stuck, stuck_level;

  pwm_capture #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .duty_code   (duty_code),
    .code_ok     (code_ok),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int per;
    int duty;
    bit ok;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mv_cnt = 0;
  int first_mv = -1;
  int phase = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: works on pin samples and edge timestamps only.
  int  now = 0, t_rise = 0, t_fall = 0, t_edge = 0;
  bit  lvl = 0, seen_r = 0, seen_f = 0, mstuck = 0;
  int  duty_m = 0;
  bit  ok_m = 0;

  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      lvl = 0; seen_r = 0; seen_f = 0; mstuck = 0;
      duty_m = 0; ok_m = 0; t_edge = now;
      q.delete();
    end else begin
      if (pwm_in && !lvl) begin
        if (seen_r && seen_f) begin
          e.hi  = t_fall - t_rise;
          e.per = now - t_rise;
          if (e.per == 16) begin
            ok_m = 1;
            duty_m = e.hi - 1;
          end else begin
            ok_m = 0;
          end
          e.duty = duty_m;
          e.ok   = ok_m;
          q.push_back(e);
        end
        seen_r = 1; seen_f = 0; t_rise = now; t_edge = now; mstuck = 0;
      end else if (!pwm_in && lvl) begin
        if (seen_r) begin
          seen_f = 1;
          t_fall = now;
        end
        t_edge = now; mstuck = 0;
      end else if (!mstuck && (now - (seen_r ? t_rise : t_edge)) >= STUCK_LIM) begin
        mstuck = 1; seen_r = 0; seen_f = 0;
        if (lvl) begin
          duty_m = 15;
          ok_m = 1;
        end
      end
      lvl = pwm_in;
    end
    now++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resetn && meas_valid) begin
      mv_cnt++;
      if (first_mv < 0) first_mv = cyc;
      if (q.size() == 0) begin
        chk("unexpected_meas_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("high_cnt", int'(high_cnt), e.hi);
        chk("period_cnt", int'(period_cnt), e.per);
        chk("duty_code", int'(duty_code), e.duty);
        chk("code_ok", int'(code_ok), int'(e.ok));
      end
    end
  end

  task automatic hold(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic gen_cycles(input int duty, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = (phase <= duty);
      phase = (phase + 1) % 16;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high_cnt"}, int'(high_cnt), 0);
    chk({tag, "_period_cnt"}, int'(period_cnt), 0);
    chk({tag, "_duty_code"}, int'(duty_code), 0);
    chk({tag, "_code_ok"}, int'(code_ok), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
    chk({tag, "_stuck_level"}, int'(stuck_level), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t0, dt, mv0, h, l;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Generator loopback, duty 5
    @(negedge clk);
    resetn = 1'b1;
    rel = cyc;
    phase = 0;
    gen_cycles(5, 16 * 6);
    chk("first_mv_latency_ok", (first_mv >= 0 && first_mv - rel <= 2 * 16 + 3) ? 1 : 0, 1);
    chk("d5_high", int'(high_cnt), 6);
    chk("d5_duty", int'(duty_code), 5);

    gen_cycles(0, 16 * 4);
    chk("d0_high", int'(high_cnt), 1);
    chk("d0_period", int'(period_cnt), 16);

    // Duty change mid-frame
    gen_cycles(3, 16 * 3 + 8);
    gen_cycles(9, 16 * 5);
    chk("d9_duty", int'(duty_code), 9);
    chk("d9_high", int'(high_cnt), 10);
    chk("d9_code_ok", int'(code_ok), 1);

    // Non-native frame: 3 high / 10 low
    repeat (5) begin
      hold(1'b1, 3);
      hold(1'b0, 10);
    end
    hold(1'b1, 1);
    repeat (3) @(negedge clk);
    chk("h3l10_high", int'(high_cnt), 3);
    chk("h3l10_period", int'(period_cnt), 13);
    chk("h3l10_code_ok", int'(code_ok), 0);
    chk("h3l10_duty_held", int'(duty_code), duty_m);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // Random waveforms, occasionally native 16-cycle frames
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(1, 15);
        l = 16 - h;
      end else begin
        h = $urandom_range(1, 100);
        l = $urandom_range(1, 100);
      end
      hold(1'b1, h);
      hold(1'b0, l);
    end

    // Stuck high (duty 15)
    hold(1'b0, 20);
    @(negedge clk);
    pwm_in = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 400 && !stuck; i++) @(negedge clk);
    dt = cyc - t0;
    chk("stuck_high_timing_ok", (dt >= STUCK_LIM && dt <= STUCK_LIM + 7) ? 1 : 0, 1);
    chk("stuck_high_level", int'(stuck_level), 1);
    chk("stuck_high_duty", int'(duty_code), 15);
    chk("stuck_high_code_ok", int'(code_ok), 1);
    mv0 = mv_cnt;
    hold(1'b1, 50);
    chk("stuck_high_no_mv", mv_cnt - mv0, 0);
    chk("stuck_high_still", int'(stuck), 1);
    hold(1'b0, 5);
    chk("stuck_clear_on_fall", int'(stuck), 0);

    // Stuck low out of LOW
    hold(1'b1, 4);
    hold(1'b0, 300);
    chk("stuck_low", int'(stuck), 1);
    chk("stuck_low_level", int'(stuck_level), 0);
    chk("stuck_low_duty_held", int'(duty_code), 15);
    chk("stuck_low_code_held", int'(code_ok), 1);
    hold(1'b1, 5);
    chk("stuck_clear_on_rise", int'(stuck), 0);

    // Reset in the middle of a high phase
    hold(1'b0, 6);
    hold(1'b1, 8);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    pwm_in = 1'b0;
    resetn = 1'b1;
    mv0 = mv_cnt;
    hold(1'b0, 200);
    chk("post_reset_no_stuck", int'(stuck), 0);
    hold(1'b1, 5);
    hold(1'b0, 5);
    repeat (4) @(negedge clk);
    chk("post_reset_no_mv_yet", mv_cnt - mv0, 0);
    hold(1'b1, 5);
    hold(1'b0, 11);
    chk("post_reset_one_mv", mv_cnt - mv0, 1);

    hold(1'b0, 10);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart to the team's 4-bit PWM generator. It samples a single asynchronous PWM input and measures high time and period in clock cycles. When the input uses the generator's native 16-cycle frame, it also recovers the 4-bit duty code. It flags a stuck (edge-less) input. It sits on a board input pin and feeds measurement results to register/readout logic.

## Interface
- CNT_W, default 8: width of the cycle counters; minimum 5, so a 16-cycle frame is representable.
- clk  input  1  single clock; all logic on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous PWM waveform.
- high_cnt  output  CNT_W  high-phase length of the last complete period, in cycles; reset 0.
- period_cnt  output  CNT_W  rise-to-rise length of the last complete period, in cycles; reset 0.
- duty_code  output  4  recovered generator duty code; reset 0.
- code_ok  output  1  last measurement was a 16-cycle frame, so duty_code is valid; reset 0.
- meas_valid  output  1  one-cycle pulse when the outputs above update; reset 0.
- stuck  output  1  no edge seen for 2^CNT_W-1 cycles; reset 0.
- stuck_level  output  1  synchronized pwm_in level while stuck=1; reset 0.

## Operation
- Input conditioning:
  - 2-flop synchronizer, then a previous-value register.
  - rise = s & ~s_d; fall = ~s & s_d. All flops reset to 0.
- FSM states:
  - WAIT_RISE (reset state): ignore everything until rise, then go to HIGH with per_ctr=1.
  - HIGH: per_ctr increments each cycle. On fall, latch hi_lat=per_ctr, then go to LOW.
  - LOW: per_ctr increments each cycle. On rise, publish, then go to HIGH with per_ctr=1.
  - STUCK: entered from any non-stuck state when per_ctr would exceed 2^CNT_W-1. Set stuck=1 and stuck_level=s.
- Leaving STUCK:
  - On rise: stuck=0, go to HIGH with per_ctr=1.
  - On fall: stuck=0, go to WAIT_RISE.
  - In WAIT_RISE, a separate idle count with the same limit also drives STUCK.
- Publish (registered, effective the cycle after rise detected):
  - high_cnt=hi_lat and period_cnt=per_ctr (the value before the restart).
  - code_ok=(per_ctr==16).
  - duty_code=hi_lat-1 when code_ok, otherwise unchanged.
  - meas_valid=1 for that single cycle.
- Stuck high (duty 15 from the generator, which never falls) forces duty_code=15 and code_ok=1 on STUCK entry with stuck_level=1. No meas_valid is issued.
- Stuck low: duty_code and code_ok are left unchanged.
- Outputs hold their last published values between publishes and while stuck.
- Simultaneous rise and saturation: rise wins; publish normally.
- A 1-cycle glitch high is measured faithfully (high_cnt=1). There is no filtering.
- Reset mid-operation clears every register, including the synchronizer. The first publish after release needs a full rise → fall → rise sequence.

## Timing
- Latency from pwm_in transition (sampled at clk edge k) to rise/fall asserted: cycle k+2.
- Latency from detected rise to meas_valid and updated outputs: +1 cycle, so 3 cycles from pin to result.
- Measurement cadence: one meas_valid per input period once locked. The first one comes after the second detected rise.
- Stuck detection fires 2^CNT_W-1 cycles after the last edge. With CNT_W=8 that is 255 cycles.
- Counters saturate; they never wrap.

## Structure
- Shared package pwm_pkg:
  - state enum {WAIT_RISE, HIGH, LOW, STUCK}.
  - PWM_PERIOD=16, DUTY_W=4.
  - The generator is also to use these constants.
- One sub-module, pwm_edge_sync: synchronizer, previous-value register, rise/fall outputs.
- The FSM, counters and publish registers live in pwm_capture.

## Test plan
- Generator loopback, duty=5:
  - every 16 cycles meas_valid, high_cnt=6, period_cnt=16, duty_code=5, code_ok=1.
  - first pulse ≤ 2 frames + 3 cycles after reset release.
- Generator duty=0: high_cnt=1, period_cnt=16, duty_code=0.
- Generator duty=15 (constant high):
  - stuck=1, stuck_level=1, duty_code=15, code_ok=1 at 255 cycles after the last edge.
  - no meas_valid thereafter.
- Duty change 3→9 mid-frame: at most one mixed measurement, then steady duty_code=9, high_cnt=10.
- Hand-driven waveform 3 high / 10 low: high_cnt=3, period_cnt=13, code_ok=0, duty_code unchanged.
- Assert resetn mid-HIGH:
  - all outputs 0 immediately.
  - after release, no meas_valid until rise, fall, rise have been applied.
  - no stuck before 255 idle cycles.
